// File: rtl/noc_params.sv
// Shared router parameters and types for the switch allocator.
// Optional macro SWITCH_ALLOC_RR_EN selects round-robin over fixed priority.
package noc_params;
   localparam int VC_NUM    = 4;
   localparam int PORT_NUM  = 5;
   localparam int VC_SIZE   = $clog2(VC_NUM);
   localparam int PORT_SIZE = $clog2(PORT_NUM);

   typedef logic [PORT_SIZE-1:0] port_t;
endpackage

// File: rtl/separable_switch_allocator_arbiter.sv
// N-way arbiter: round-robin with pointer under SWITCH_ALLOC_RR_EN,
// otherwise fixed priority (lowest index) with no state.
module round_robin_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   output logic [N-1:0] gnt_o
);
   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0] ptr;
   logic         found;
   int           win;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_i[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            win   = (int'(ptr) + k) % N;
         end
      end
      if (found) gnt_o[win] = 1'b1;
   end

`ifdef SWITCH_ALLOC_RR_EN
   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   // Pointer moves past the winner only when its grant is actually used.
   always_comb begin
      ptr_d = ptr_q;
      if (en_i && found) ptr_d = W'((win + 1) % N);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`else
   logic unused_ok;
   assign unused_ok = ^{clk, rst, en_i};
   assign ptr       = '0;
`endif
endmodule

// File: rtl/separable_switch_allocator.sv
// Two-stage input-first separable switch allocator (VC pick, then port pick).
// SWITCH_ALLOC_RR_EN enables round-robin pointers; default is fixed priority.
module separable_switch_allocator
   import noc_params::*;
#(
   parameter int PORT_NUM = noc_params::PORT_NUM
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]       request_i,
   input  port_t [PORT_NUM-1:0][VC_NUM-1:0]       out_port_i,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]       on_off_i,
   output logic  [PORT_NUM-1:0]                   valid_sel_o,
   output logic  [PORT_NUM-1:0][VC_SIZE-1:0]      vc_sel_o,
   output logic  [PORT_NUM-1:0][$clog2(PORT_NUM)-1:0] xbar_sel_o,
   output logic  [PORT_NUM-1:0]                   valid_flit_o
);
   localparam int SEL_W = $clog2(PORT_NUM);

   logic  [PORT_NUM-1:0][VC_NUM-1:0]   elig;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]   s1_gnt;
   logic  [PORT_NUM-1:0][VC_SIZE-1:0]  cand_vc;
   port_t [PORT_NUM-1:0]               cand_port;
   logic  [PORT_NUM-1:0]               cand_v;
   logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;
   logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_gnt;

   // Reset gates eligibility so every grant vanishes asynchronously.
   always_comb begin
      elig = '0;
      for (int ip = 0; ip < PORT_NUM; ip++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (!rst && request_i[ip][v] &&
                int'(out_port_i[ip][v]) < PORT_NUM)
               elig[ip][v] =
                  on_off_i[out_port_i[ip][v]][downstream_vc_i[ip][v]];
         end
      end
   end

   for (genvar ip = 0; ip < PORT_NUM; ip++) begin : g_in
      round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
         .clk   (clk),
         .rst   (rst),
         .req_i (elig[ip]),
         .en_i  (valid_sel_o[ip]),
         .gnt_o (s1_gnt[ip])
      );
   end

   always_comb begin
      cand_vc   = '0;
      cand_port = '0;
      cand_v    = '0;
      for (int ip = 0; ip < PORT_NUM; ip++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (s1_gnt[ip][v]) begin
               cand_vc[ip]   = VC_SIZE'(v);
               cand_port[ip] = out_port_i[ip][v];
               cand_v[ip]    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      s2_req = '0;
      for (int op = 0; op < PORT_NUM; op++) begin
         for (int ip = 0; ip < PORT_NUM; ip++) begin
            s2_req[op][ip] = cand_v[ip] && (int'(cand_port[ip]) == op);
         end
      end
   end

   for (genvar op = 0; op < PORT_NUM; op++) begin : g_out
      round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
         .clk   (clk),
         .rst   (rst),
         .req_i (s2_req[op]),
         .en_i  (valid_flit_o[op]),
         .gnt_o (s2_gnt[op])
      );
   end

   always_comb begin
      valid_sel_o  = '0;
      vc_sel_o     = '0;
      xbar_sel_o   = '0;
      valid_flit_o = '0;
      for (int op = 0; op < PORT_NUM; op++) begin
         for (int ip = 0; ip < PORT_NUM; ip++) begin
            if (s2_gnt[op][ip]) begin
               valid_sel_o[ip]  = 1'b1;
               xbar_sel_o[op]   = SEL_W'(ip);
               valid_flit_o[op] = 1'b1;
            end
         end
      end
      for (int ip = 0; ip < PORT_NUM; ip++) begin
         if (valid_sel_o[ip]) vc_sel_o[ip] = cand_vc[ip];
      end
   end
endmodule

// File: tb/tb_separable_switch_allocator.sv
// Scoreboard bench for separable_switch_allocator (RR or fixed priority,
// following SWITCH_ALLOC_RR_EN).
module tb_separable_switch_allocator;
   import noc_params::*;

   localparam int P = PORT_NUM;
   localparam int V = VC_NUM;
   localparam int PS = $clog2(P);

`ifdef SWITCH_ALLOC_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic [P-1:0]          vs;
      logic [P-1:0][VC_SIZE-1:0] vc;
      logic [P-1:0][PS-1:0]  xb;
      logic [P-1:0]          vf;
   } exp_t;

   logic clk;
   logic rst;
   logic  [P-1:0][V-1:0]              request_i;
   port_t [P-1:0][V-1:0]              out_port_i;
   logic  [P-1:0][V-1:0][VC_SIZE-1:0] downstream_vc_i;
   logic  [P-1:0][V-1:0]              on_off_i;
   logic  [P-1:0]                     valid_sel_o;
   logic  [P-1:0][VC_SIZE-1:0]        vc_sel_o;
   logic  [P-1:0][PS-1:0]             xbar_sel_o;
   logic  [P-1:0]                     valid_flit_o;

   int   total = 0;
   int   bad   = 0;
   int   m_in[P];
   int   m_out[P];
   exp_t sb[$];

   separable_switch_allocator dut (
      .clk             (clk),
      .rst             (rst),
      .request_i       (request_i),
      .out_port_i      (out_port_i),
      .downstream_vc_i (downstream_vc_i),
      .on_off_i        (on_off_i),
      .valid_sel_o     (valid_sel_o),
      .vc_sel_o        (vc_sel_o),
      .xbar_sel_o      (xbar_sel_o),
      .valid_flit_o    (valid_flit_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model();
      exp_t e;
      int   cv[P];
      int   cp[P];
      bit   ok[P];
      bit   done;
      int   v;
      int   ip;
      e = '0;
      for (int i = 0; i < P; i++) begin
         ok[i] = 0; cv[i] = 0; cp[i] = 0;
         for (int k = 0; k < V; k++) begin
            v = (m_in[i] + k) % V;
            if (!ok[i] && request_i[i][v] && int'(out_port_i[i][v]) < P &&
                on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]]) begin
               ok[i] = 1; cv[i] = v; cp[i] = int'(out_port_i[i][v]);
            end
         end
      end
      for (int op = 0; op < P; op++) begin
         done = 0;
         for (int k = 0; k < P; k++) begin
            ip = (m_out[op] + k) % P;
            if (!done && ok[ip] && cp[ip] == op) begin
               done = 1;
               e.vs[ip] = 1'b1;
               e.vc[ip] = VC_SIZE'(cv[ip]);
               e.xb[op] = PS'(ip);
               e.vf[op] = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic clear_inputs();
      request_i       = '0;
      out_port_i      = '0;
      downstream_vc_i = '0;
      on_off_i        = '1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < P; i++) begin
         m_in[i] = 0; m_out[i] = 0;
      end
   endtask

   // Push expectation, compare away from the edge, then advance model pointers.
   task automatic step(input string name);
      exp_t e;
      sb.push_back(model());
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({valid_sel_o, vc_sel_o, xbar_sel_o, valid_flit_o} !==
          {e.vs, e.vc, e.xb, e.vf}) begin
         bad++;
         $display("FAIL %s: got vs=%h vc=%h xb=%h vf=%h want vs=%h vc=%h xb=%h vf=%h",
                  name, valid_sel_o, vc_sel_o, xbar_sel_o, valid_flit_o,
                  e.vs, e.vc, e.xb, e.vf);
      end
      @(posedge clk);
      if (RR) begin
         for (int i = 0; i < P; i++) begin
            if (e.vs[i]) m_in[i] = (int'(e.vc[i]) + 1) % V;
            if (e.vf[i]) m_out[i] = (int'(e.xb[i]) + 1) % P;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      request_i       = '1;
      out_port_i      = '0;
      downstream_vc_i = '0;
      on_off_i        = '1;
      #2;
      total++;
      if ({valid_sel_o, vc_sel_o, xbar_sel_o, valid_flit_o} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got vs=%h vf=%h want 0",
                  valid_sel_o, valid_flit_o);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      request_i[1][2]  = 1'b1;
      out_port_i[1][2] = 3'd3;
      #1;
      total++;
      if (!(valid_sel_o[1] === 1'b1 && vc_sel_o[1] === 2'd2 &&
            xbar_sel_o[3] === 3'd1 && valid_flit_o[3] === 1'b1)) begin
         bad++;
         $display("FAIL single: got vs=%h vc1=%0d xb3=%0d vf=%h want vs[1]=1 vc1=2 xb3=1 vf[3]=1",
                  valid_sel_o, vc_sel_o[1], xbar_sel_o[3], valid_flit_o);
      end
      step("single");
      request_i[1]     = 4'b1101;
      out_port_i[1][0] = 3'd3;
      out_port_i[1][3] = 3'd3;
      #1;
      total++;
      if (vc_sel_o[1] !== (RR ? 2'd3 : 2'd0)) begin
         bad++;
         $display("FAIL in_ptr_advance: got vc1=%0d want %0d",
                  vc_sel_o[1], RR ? 3 : 0);
      end
      step("single_next");
   endtask

   task automatic test_contention();
      int seq_rr[4] = '{0, 2, 0, 2};
      int want;
      do_reset();
      request_i[0][0]  = 1'b1;
      out_port_i[0][0] = 3'd4;
      request_i[2][0]  = 1'b1;
      out_port_i[2][0] = 3'd4;
      for (int i = 0; i < 4; i++) begin
         #1;
         want = RR ? seq_rr[i] : 0;
         total++;
         if (!(valid_flit_o[4] === 1'b1 && int'(xbar_sel_o[4]) == want)) begin
            bad++;
            $display("FAIL contention[%0d]: got xb4=%0d vf4=%b want %0d",
                     i, xbar_sel_o[4], valid_flit_o[4], want);
         end
         step("contention");
      end
   endtask

   task automatic test_flow();
      do_reset();
      request_i[3][0]       = 1'b1;
      out_port_i[3][0]      = 3'd4;
      downstream_vc_i[3][0] = 2'd1;
      on_off_i[4][1]        = 1'b0;
      #1;
      total++;
      if (valid_flit_o !== '0 || valid_sel_o !== '0) begin
         bad++;
         $display("FAIL flow_off: got vf=%h vs=%h want 0", valid_flit_o, valid_sel_o);
      end
      step("flow_off");
      on_off_i[4][1] = 1'b1;
      #1;
      total++;
      if (!(valid_flit_o[4] === 1'b1 && xbar_sel_o[4] === 3'd3)) begin
         bad++;
         $display("FAIL flow_on: got vf=%h xb4=%0d want vf[4]=1 xb4=3",
                  valid_flit_o, xbar_sel_o[4]);
      end
      step("flow_on");
   endtask

   task automatic test_vc_rotation();
      int want;
      do_reset();
      request_i[0] = 4'b1111;
      for (int v = 0; v < V; v++) out_port_i[0][v] = port_t'(v);
      for (int i = 0; i < 5; i++) begin
         #1;
         want = RR ? (i % V) : 0;
         total++;
         if (int'(vc_sel_o[0]) != want || valid_sel_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL vc_rotation[%0d]: got vc0=%0d vs0=%b want %0d",
                     i, vc_sel_o[0], valid_sel_o[0], want);
         end
         step("vc_rotation");
      end
   endtask

   task automatic test_stage2_hold();
      do_reset();
      request_i[0][0]  = 1'b1;
      out_port_i[0][0] = 3'd1;
      step("hold_prime");
      request_i[0]     = 4'b0011;
      out_port_i[0][1] = 3'd1;
      request_i[1][0]  = 1'b1;
      out_port_i[1][0] = 3'd1;
      #1;
      total++;
      if (valid_sel_o[0] !== (RR ? 1'b0 : 1'b1)) begin
         bad++;
         $display("FAIL hold_loss: got vs0=%b want %b", valid_sel_o[0], !RR);
      end
      step("hold_loss");
      #1;
      total++;
      if (!(valid_sel_o[0] === 1'b1 && vc_sel_o[0] === (RR ? 2'd1 : 2'd0))) begin
         bad++;
         $display("FAIL hold_retry: got vs0=%b vc0=%0d want 1/%0d",
                  valid_sel_o[0], vc_sel_o[0], RR ? 1 : 0);
      end
      step("hold_retry");
   endtask

   task automatic test_reset_mid();
      do_reset();
      request_i[0][0]  = 1'b1;
      out_port_i[0][0] = 3'd4;
      request_i[2][0]  = 1'b1;
      out_port_i[2][0] = 3'd4;
      step("mid_pre");
      rst = 1'b1;
      #1;
      total++;
      if ({valid_sel_o, vc_sel_o, xbar_sel_o, valid_flit_o} !== '0) begin
         bad++;
         $display("FAIL reset_mid: got vs=%h vf=%h want 0", valid_sel_o, valid_flit_o);
      end
      for (int i = 0; i < P; i++) begin
         m_in[i] = 0; m_out[i] = 0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      total++;
      if (!(valid_flit_o[4] === 1'b1 && xbar_sel_o[4] === 3'd0)) begin
         bad++;
         $display("FAIL reset_release: got xb4=%0d vf4=%b want 0/1",
                  xbar_sel_o[4], valid_flit_o[4]);
      end
      step("mid_post");
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 40; c++) begin
         request_i = P'(0);
         for (int i = 0; i < P; i++) begin
            request_i[i] = V'($urandom);
            on_off_i[i]  = V'($urandom | $urandom);
            for (int v = 0; v < V; v++) begin
               out_port_i[i][v]      = port_t'($urandom_range(0, P - 1));
               downstream_vc_i[i][v] = VC_SIZE'($urandom_range(0, V - 1));
            end
         end
         step("random");
      end
   endtask

   initial begin
      for (int i = 0; i < P; i++) begin
         m_in[i] = 0; m_out[i] = 0;
      end
      test_reset();
      test_single();
      test_contention();
      test_flow();
      test_vc_rotation();
      test_stage2_hold();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
